// File: rtl/hex_digit_latch.sv
// Debounced four-digit seven-segment latch: qualifies {sel_ni, seg_i} over STABLE_CYCLES edges.
// Optional per-digit blanking on refresh timeout is enabled by defining HEX_LATCH_TIMEOUT_EN.
module hex_digit_latch #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] seg_i,
    input  logic [7:0] sel_ni,
    output logic [7:0] hex0_o,
    output logic [7:0] hex1_o,
    output logic [7:0] hex2_o,
    output logic [7:0] hex3_o,
    output logic       commit_o,
    output logic [1:0] commit_digit_o
);

    typedef enum logic [1:0] {StIdle, StQual, StHold} state_e;

    localparam logic [7:0] StableThr = 8'(STABLE_CYCLES);

    state_e      state_q;
    logic [15:0] samp_q;
    logic [7:0]  cnt_q;
    logic [7:0]  hex_q [4];
    logic        commit_q;
    logic [1:0]  commit_digit_q;

    logic [15:0] in_w;
    logic        changed;
    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic [7:0]  cnt_next;
    logic        do_write;

    assign in_w    = {sel_ni, seg_i};
    assign changed = (in_w != samp_q);

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (sel_ni)
            8'hF7:   sel_idx = 2'd0;
            8'hFB:   sel_idx = 2'd1;
            8'hFD:   sel_idx = 2'd2;
            8'hFE:   sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase
    end

    // Count value this edge would produce; a change restarts at 1, otherwise saturating increment.
    always_comb begin
        cnt_next = cnt_q;
        if (changed) begin
            cnt_next = 8'd1;
        end else if (cnt_q != 8'hFF) begin
            cnt_next = cnt_q + 8'd1;
        end
    end

    assign do_write = sel_valid && (changed || (state_q == StQual)) && (cnt_next >= StableThr);

`ifdef HEX_LATCH_TIMEOUT_EN
    localparam logic [24:0] TmoLast = 25'(TIMEOUT_CYCLES - 1);
    logic [24:0] tmo_q [4];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            samp_q         <= 16'h0000;
            cnt_q          <= 8'd0;
            commit_q       <= 1'b0;
            commit_digit_q <= 2'd0;
            for (int d = 0; d < 4; d++) begin
                hex_q[d] <= 8'hFF;
`ifdef HEX_LATCH_TIMEOUT_EN
                tmo_q[d] <= 25'd0;
`endif
            end
        end else begin
            samp_q   <= in_w;
            commit_q <= do_write;
            if (do_write) begin
                commit_digit_q <= sel_idx;
            end

            if (changed) begin
                if (sel_valid) begin
                    state_q <= do_write ? StHold : StQual;
                    cnt_q   <= cnt_next;
                end else begin
                    state_q <= StIdle;
                    cnt_q   <= 8'd0;
                end
            end else if (state_q == StQual) begin
                cnt_q <= cnt_next;
                if (do_write) begin
                    state_q <= StHold;
                end
            end

            for (int d = 0; d < 4; d++) begin
                if (do_write && (sel_idx == 2'(d))) begin
                    hex_q[d] <= ~seg_i;
`ifdef HEX_LATCH_TIMEOUT_EN
                    tmo_q[d] <= 25'd0;
                end else begin
                    if (tmo_q[d] != 25'h1FF_FFFF) begin
                        tmo_q[d] <= tmo_q[d] + 25'd1;
                    end
                    // Blank on the edge where the counter reaches TIMEOUT_CYCLES.
                    if (tmo_q[d] >= TmoLast) begin
                        hex_q[d] <= 8'hFF;
                    end
`endif
                end
            end
        end
    end

    assign hex0_o         = hex_q[0];
    assign hex1_o         = hex_q[1];
    assign hex2_o         = hex_q[2];
    assign hex3_o         = hex_q[3];
    assign commit_o       = commit_q;
    assign commit_digit_o = commit_digit_q;

endmodule
